// File: rtl/calc_display_scanner.sv
// Time-multiplexes NUM_CH W-bit fields onto one display bus with dwell, blank gap and one-hot digit select.
// Optional channel blinking is compiled in when the macro CALC_DISP_BLINK_EN is defined.
module calc_display_scanner #(
  parameter int            W          = 4,
  parameter int            NUM_CH     = 4,
  parameter int            DWELL      = 50000,
  parameter int            GAP_CYCLES = 2,
  parameter logic [W-1:0]  BLANK_CODE = W'(4'b1010)
`ifdef CALC_DISP_BLINK_EN
  ,
  parameter int            BLINK_HALF = 12500000
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*W-1:0]         ch_data,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic                        mode,
  input  logic                        step,
  input  logic                        freeze,
`ifdef CALC_DISP_BLINK_EN
  input  logic [NUM_CH-1:0]           blink_mask,
`endif
  output logic [W-1:0]                display_out,
  output logic [NUM_CH-1:0]           sel_onehot,
  output logic [$clog2(NUM_CH)-1:0]   sel_idx,
  output logic                        wrap
);

  localparam int                IW         = $clog2(NUM_CH);
  localparam int                DW         = $clog2(DWELL + 1);
  localparam logic [IW-1:0]     LAST_IDX   = IW'(NUM_CH - 1);
  localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic {SHOW, GAP} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [DW-1:0]       dwell_cnt;
  logic                wrap_pend;
  logic                gap_last;
  logic                blink_hide;
  logic                adv_p0;
  logic                vld_p0;
  logic [W-1:0]        disp_p0;
  logic [NUM_CH-1:0]   onehot_p0;
  logic [W-1:0]        field_p0 [NUM_CH];

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
    return (cur == LAST_IDX) ? '0 : cur + 1'b1;
  endfunction

  function automatic logic is_wrap(input logic [IW-1:0] cur);
    return (cur == LAST_IDX);
  endfunction

  // Stage p0: field selection for the channel currently addressed by idx
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      field_p0[i] = ch_data[i*W +: W];
    end
  end

  always_comb begin
    vld_p0    = ch_valid[idx] & ~blink_hide;
    disp_p0   = vld_p0 ? field_p0[idx] : BLANK_CODE;
    onehot_p0 = {{(NUM_CH-1){1'b0}}, 1'b1} << idx;
    adv_p0    = mode ? step : (dwell_cnt == DWELL_LAST);
  end

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      localparam int            GW       = $clog2(GAP_CYCLES + 1);
      localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
      logic [GW-1:0] gap_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          gap_cnt <= '0;
        end else if (!freeze) begin
          if (state == GAP && gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else begin
            gap_cnt <= '0;
          end
        end
      end

      assign gap_last = (gap_cnt == GAP_LAST);
    end else begin : g_nogap
      assign gap_last = 1'b1;
    end
  endgenerate

`ifdef CALC_DISP_BLINK_EN
  localparam int            BW        = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BLINK_END = BW'(BLINK_HALF - 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // Free-running blink phase; starts "on" after reset and pauses while frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!freeze) begin
      if (blink_cnt == BLINK_END) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_hide = blink_mask[idx] & ~blink_on;
`else
  assign blink_hide = 1'b0;
`endif

  // Stage p1: scan FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SHOW;
      idx         <= '0;
      dwell_cnt   <= '0;
      wrap_pend   <= 1'b0;
      display_out <= BLANK_CODE;
      sel_onehot  <= '0;
      sel_idx     <= '0;
      wrap        <= 1'b0;
    end else if (freeze) begin
      wrap <= 1'b0;
    end else begin
      sel_idx   <= idx;
      wrap      <= wrap_pend;
      wrap_pend <= 1'b0;
      case (state)
        SHOW: begin
          display_out <= disp_p0;
          sel_onehot  <= onehot_p0;
          if (adv_p0) begin
            dwell_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              idx       <= next_idx(idx);
              wrap_pend <= is_wrap(idx);
            end
          end else if (mode) begin
            dwell_cnt <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        GAP: begin
          display_out <= BLANK_CODE;
          sel_onehot  <= '0;
          // wrap is raised one cycle later, when the output actually lands on channel 0
          if (gap_last) begin
            state     <= SHOW;
            idx       <= next_idx(idx);
            wrap_pend <= is_wrap(idx);
            dwell_cnt <= '0;
          end
        end
        default: begin
          state <= SHOW;
        end
      endcase
    end
  end

endmodule
